// File: rtl/mandel_tile_scheduler.sv
// Mandelbrot tile scheduler: hands tile indices to iterator cores
// round-robin and tracks completions for the HPS status poll.
module mandel_tile_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [IDX_W-1:0]     num_tiles,
  input  logic [NUM_CORES-1:0] core_ready,
  input  logic [NUM_CORES-1:0] core_done,
  output logic [NUM_CORES-1:0] core_start,
  output logic [IDX_W-1:0]     core_tile,
  output logic                 busy,
  output logic                 all_done,
  output logic [IDX_W-1:0]     tiles_done,
  output logic                 err
);

  localparam int RR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [RR_W:0] NC = (RR_W+1)'(NUM_CORES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DISP  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 start_q;
  logic [IDX_W-1:0]     total_q, total_d;
  logic [IDX_W-1:0]     next_tile_q, next_tile_d;
  logic [IDX_W-1:0]     tiles_done_q, tiles_done_d;
  logic [NUM_CORES-1:0] busy_mask_q, busy_mask_d;
  logic                 err_q, err_d;
  logic                 all_done_q, all_done_d;
  logic [RR_W-1:0]      rr_q, rr_d;
  logic [NUM_CORES-1:0] core_start_q, core_start_d;
  logic [IDX_W-1:0]     core_tile_q, core_tile_d;

  logic                 start_rise;
  logic [NUM_CORES-1:0] elig;
  logic [NUM_CORES-1:0] acc;
  logic [NUM_CORES-1:0] spur;
  logic [IDX_W-1:0]     acc_cnt;
  logic                 gnt_vld;
  logic [RR_W-1:0]      gnt_idx;
  logic [RR_W-1:0]      gnt_nxt;
  logic [RR_W:0]        sum;
  logic [RR_W:0]        nsum;

  assign start_rise = start & ~start_q;

  // Round-robin search for the first eligible core at or after rr.
  always_comb begin
    elig    = core_ready & ~busy_mask_q;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      sum = {1'b0, rr_q} + (RR_W+1)'(k);
      if (sum >= NC) sum = sum - NC;
      if (!gnt_vld && elig[sum[RR_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = sum[RR_W-1:0];
      end
    end
    nsum = {1'b0, gnt_idx} + (RR_W+1)'(1);
    if (nsum >= NC) nsum = '0;
    gnt_nxt = nsum[RR_W-1:0];
  end

  // Split done pulses into accepted (core was busy) and spurious ones.
  always_comb begin
    acc     = core_done & busy_mask_q;
    spur    = core_done & ~busy_mask_q;
    acc_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      acc_cnt = acc_cnt + IDX_W'(acc[i]);
    end
  end

  // Job control FSM with dispatch and completion bookkeeping.
  always_comb begin
    state_d      = state_q;
    total_d      = total_q;
    next_tile_d  = next_tile_q;
    tiles_done_d = tiles_done_q;
    busy_mask_d  = busy_mask_q;
    err_d        = err_q;
    all_done_d   = all_done_q;
    rr_d         = rr_q;
    core_start_d = '0;
    core_tile_d  = core_tile_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          total_d      = num_tiles;
          next_tile_d  = '0;
          tiles_done_d = '0;
          busy_mask_d  = '0;
          err_d        = 1'b0;
          if (num_tiles == '0) begin
            state_d    = S_DONE;
            all_done_d = 1'b1;
          end else begin
            state_d    = S_DISP;
            all_done_d = 1'b0;
          end
        end
      end
      S_DISP, S_DRAIN: begin
        busy_mask_d  = busy_mask_q & ~acc;
        err_d        = err_q | (|spur);
        tiles_done_d = tiles_done_q + acc_cnt;
        if (state_q == S_DISP && gnt_vld) begin
          core_start_d = NUM_CORES'(1) << gnt_idx;
          core_tile_d  = next_tile_q;
          busy_mask_d  = busy_mask_d | core_start_d;
          next_tile_d  = next_tile_q + IDX_W'(1);
          rr_d         = gnt_nxt;
          if (next_tile_d == total_q) state_d = S_DRAIN;
        end
        if (tiles_done_d == total_q) begin
          state_d    = S_DONE;
          all_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      total_q      <= '0;
      next_tile_q  <= '0;
      tiles_done_q <= '0;
      busy_mask_q  <= '0;
      err_q        <= 1'b0;
      all_done_q   <= 1'b0;
      rr_q         <= '0;
      core_start_q <= '0;
      core_tile_q  <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      total_q      <= total_d;
      next_tile_q  <= next_tile_d;
      tiles_done_q <= tiles_done_d;
      busy_mask_q  <= busy_mask_d;
      err_q        <= err_d;
      all_done_q   <= all_done_d;
      rr_q         <= rr_d;
      core_start_q <= core_start_d;
      core_tile_q  <= core_tile_d;
    end
  end

  assign core_start = core_start_q;
  assign core_tile  = core_tile_q;
  assign busy       = (state_q == S_DISP) | (state_q == S_DRAIN);
  assign all_done   = all_done_q;
  assign tiles_done = tiles_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mandel_tile_scheduler.sv
// Directed bench for mandel_tile_scheduler with a dispatch
// scoreboard and a simple auto-completing core model.
module tb_mandel_tile_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [9:0] num_tiles;
  logic [3:0] core_ready;
  logic [3:0] man_done;
  logic [3:0] auto_done = '0;
  logic [3:0] core_done;
  logic [3:0] core_start;
  logic [9:0] core_tile;
  logic       busy;
  logic       all_done;
  logic [9:0] tiles_done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int exp_core[$];
  int exp_tile[$];
  bit auto_en = 1'b0;
  int cnt[4] = '{0, 0, 0, 0};
  logic [3:0] outst = '0;
  logic [3:0] done_s = '0;
  logic       rst_s = 1'b0;

  always #5 clk = ~clk;

  assign core_done = man_done | auto_done;

  mandel_tile_scheduler #(.NUM_CORES(4), .IDX_W(10)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .num_tiles(num_tiles),
    .core_ready(core_ready),
    .core_done(core_done),
    .core_start(core_start),
    .core_tile(core_tile),
    .busy(busy),
    .all_done(all_done),
    .tiles_done(tiles_done),
    .err(err)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(int c, int t);
    exp_core.push_back(c);
    exp_tile.push_back(t);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    man_done = '0;
    tick(2);
    reset_n  = 1'b1;
    tick(1);
  endtask

  task automatic wait_done(int maxc, string tag);
    int n;
    n = 0;
    while (!all_done && n < maxc) begin
      tick(1);
      n++;
    end
    chk({tag, "_timeout"}, 32'(all_done), 32'd1);
  endtask

  // Sample what the DUT consumed at the last rising edge.
  always @(posedge clk) begin
    done_s <= core_done;
    rst_s  <= reset_n;
  end

  // Core model and dispatch scoreboard.
  always @(negedge clk) begin
    int c;
    int t;
    auto_done = '0;
    if (!rst_s) begin
      outst = '0;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
    end else begin
      outst = outst & ~done_s;
      for (int i = 0; i < 4; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) auto_done[i] = 1'b1;
        end
      end
    end
    if (core_start != '0) begin
      chk("onehot", 32'($onehot(core_start)), 32'd1);
      if (exp_core.size() == 0) begin
        chk("unexpected_dispatch", 32'(core_start), 32'd0);
      end else begin
        c = exp_core.pop_front();
        t = exp_tile.pop_front();
        chk("sb_core", 32'(core_start), 32'(1) << c);
        chk("sb_tile", 32'(core_tile), 32'(t));
      end
      for (int i = 0; i < 4; i++) begin
        if (core_start[i]) begin
          chk("one_outstanding", 32'(outst[i]), 32'd0);
          outst[i] = 1'b1;
          if (auto_en) cnt[i] = 5;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    num_tiles  = '0;
    core_ready = '0;
    man_done   = '0;
    do_reset();
    chk("rst_core_start", 32'(core_start), 0);
    chk("rst_core_tile", 32'(core_tile), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_all_done", 32'(all_done), 0);
    chk("rst_tiles_done", 32'(tiles_done), 0);
    chk("rst_err", 32'(err), 0);

    // single tile
    core_ready = 4'hF;
    push(0, 0);
    num_tiles = 10'd1;
    start = 1'b1;
    tick(1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_no_start_yet", 32'(core_start), 0);
    tick(1);
    chk("t1_core_start", 32'(core_start), 32'b0001);
    chk("t1_tile", 32'(core_tile), 0);
    man_done = 4'b0001;
    tick(1);
    man_done = '0;
    chk("t1_all_done", 32'(all_done), 1);
    chk("t1_tiles_done", 32'(tiles_done), 1);
    chk("t1_busy_low", 32'(busy), 0);

    // round-robin fill with auto completions
    do_reset();
    auto_en = 1'b1;
    push(0, 0); push(1, 1); push(2, 2);
    push(3, 3); push(0, 4); push(1, 5);
    num_tiles = 10'd6;
    start = 1'b1;
    tick(2);
    for (int k = 0; k < 4; k++) begin
      chk("rr_consecutive", 32'(core_start), 32'(1) << k);
      tick(1);
    end
    wait_done(100, "rr");
    chk("rr_tiles_done", 32'(tiles_done), 6);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_sb_empty", 32'(exp_core.size()), 0);

    // blocked readiness: only core 2
    do_reset();
    core_ready = 4'b0100;
    push(2, 0); push(2, 1); push(2, 2);
    num_tiles = 10'd3;
    start = 1'b1;
    wait_done(200, "blk");
    chk("blk_tiles_done", 32'(tiles_done), 3);
    chk("blk_sb_empty", 32'(exp_core.size()), 0);

    // four simultaneous dones
    do_reset();
    auto_en = 1'b0;
    core_ready = 4'hF;
    push(0, 0); push(1, 1); push(2, 2); push(3, 3);
    num_tiles = 10'd4;
    start = 1'b1;
    tick(5);
    chk("sim_last_grant", 32'(core_start), 32'b1000);
    chk("sim_tiles_before", 32'(tiles_done), 0);
    chk("sim_all_done_before", 32'(all_done), 0);
    man_done = 4'hF;
    tick(1);
    man_done = '0;
    chk("sim_tiles_after", 32'(tiles_done), 4);
    chk("sim_all_done", 32'(all_done), 1);
    chk("sim_busy", 32'(busy), 0);

    // spurious done from idle core 3
    do_reset();
    core_ready = 4'b0001;
    push(0, 0); push(0, 1);
    num_tiles = 10'd2;
    start = 1'b1;
    tick(2);
    chk("sp_grant0", 32'(core_start), 32'b0001);
    man_done = 4'b1000;
    tick(1);
    man_done = '0;
    chk("sp_err", 32'(err), 1);
    chk("sp_tiles_unchanged", 32'(tiles_done), 0);
    man_done = 4'b0001;
    tick(1);
    man_done = '0;
    chk("sp_tiles_one", 32'(tiles_done), 1);
    tick(1);
    chk("sp_regrant", 32'(core_start), 32'b0001);
    chk("sp_regrant_tile", 32'(core_tile), 1);
    man_done = 4'b0001;
    tick(1);
    man_done = '0;
    chk("sp_all_done", 32'(all_done), 1);
    chk("sp_err_sticky", 32'(err), 1);

    // restart from DONE; rr continues at core 1
    start = 1'b0;
    tick(1);
    core_ready = 4'hF;
    auto_en = 1'b1;
    push(1, 0);
    num_tiles = 10'd1;
    start = 1'b1;
    tick(1);
    chk("rs_err_cleared", 32'(err), 0);
    chk("rs_all_done_fell", 32'(all_done), 0);
    chk("rs_busy", 32'(busy), 1);
    wait_done(50, "rs");
    chk("rs_tiles_done", 32'(tiles_done), 1);
    tick(5);
    chk("held_all_done", 32'(all_done), 1);
    chk("held_busy", 32'(busy), 0);
    chk("rs_sb_empty", 32'(exp_core.size()), 0);

    // zero-tile job
    do_reset();
    auto_en = 1'b0;
    num_tiles = 10'd0;
    start = 1'b1;
    tick(1);
    chk("z_all_done", 32'(all_done), 1);
    chk("z_busy", 32'(busy), 0);
    chk("z_tiles", 32'(tiles_done), 0);
    tick(3);
    chk("z_no_start", 32'(core_start), 0);

    // reset in the middle of a job
    start = 1'b0;
    tick(1);
    push(0, 0); push(1, 1);
    num_tiles = 10'd8;
    start = 1'b1;
    tick(3);
    reset_n = 1'b0;
    start = 1'b0;
    tick(1);
    chk("mr_core_start", 32'(core_start), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_all_done", 32'(all_done), 0);
    chk("mr_tiles", 32'(tiles_done), 0);
    chk("mr_err", 32'(err), 0);
    reset_n = 1'b1;
    tick(5);
    chk("mr_quiet", 32'(core_start), 0);
    chk("mr_sb_empty", 32'(exp_core.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
